ahb_transfer_handler: RTL and testbench
=======================================

// Module: ahb_transfer_handler
// PURPOSE
//  AHB-Lite burst sequencer on the I-cache refill side.
//  Takes a requested address and issues one AHB burst of the type on hburst.
//  Drives htrans and the beat address (read_addr), and captures returned hrdata into read_data.
//  Sits between the cache miss logic and the AHB-Lite bus.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width; beat stride is DATA_W/8 bytes (4)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       reset: synchronous, active-high
//  addr       in   ADDR_W  requested burst start address
//  hwrite     in   1       1 = write burst (no read capture)
//  hrdata     in   DATA_W  AHB read data
//  hready     in   1       AHB ready; completes the current data phase and accepts the address phase
//  hwdata     in   DATA_W  write data, monitored only, never stored
//  hburst     in   3       AHB burst type (000 SINGLE .. 111 INCR16)
//  htrans     out  2       AHB transfer type: 00 IDLE, 10 NONSEQ, 11 SEQ; BUSY is never issued
//  read_addr  out  ADDR_W  address of the beat in its address phase (HADDR)
//  read_data  out  DATA_W  last captured read beat
// BEHAVIOUR
//  Reset (rst=1 at a clock edge)
//   - htrans=00, read_addr=0, read_data=0.
//   - State goes to IDLE; start_valid=0; all counters are cleared.
//   - Reset mid-burst aborts the burst at once. No further beats are issued or captured.
//  Beat count by hburst
//   - SINGLE=1, INCR=4, WRAP4=4, INCR4=4.
//   - WRAP8=8, INCR8=8, WRAP16=16, INCR16=16.
//   - INCR (undefined length) is fixed at 4 beats.
//  States: IDLE, ADDR, DRAIN.
//  Start (in IDLE)
//   - A = {addr[31:2],2'b00}.
//   - A burst starts if !start_valid or A != last_start.
//   - On start: last_start<=A, start_valid<=1.
//   - On start, latch hburst, hwrite and beat count; these stay fixed for the whole burst.
//   - Next cycle: htrans=10, read_addr=A, state=ADDR.
//   - addr changes during a burst are ignored until IDLE, then compared as above.
//  ADDR state
//   - htrans and read_addr hold while hready=0.
//   - On hready=1 the address phase is accepted and issued++.
//   - If beats remain: read_addr<=next, htrans<=11.
//   - If no beats remain: htrans<=00, state=DRAIN.
//  Next address
//   - INCR types: cur+4.
//   - WRAP types: (cur & ~M) | ((cur+4) & M), where M = beats*4-1.
//  Data phase
//   - pend is set when an address phase is accepted.
//   - On hready=1 with pend and the latched hwrite=0: read_data<=hrdata.
//   - Pipelined: the edge that accepts beat n+1 address also completes beat n data.
//   - In DRAIN, hready=1 completes the final beat; state goes to IDLE.
//   - Minimum one htrans=00 cycle between bursts.
//  Write bursts: address/htrans sequencing is identical; read_data is held.
//  Latency: start decision to first NONSEQ is 1 cycle.
//   With hready held at 1, an N-beat burst occupies N+1 cycles from the first NONSEQ to the IDLE return.
//  1KB-boundary crossing is the requester's responsibility and is not checked.
// STRUCTURE
//  Package ahb_pkg holds:
//   - htrans_e {IDLE,BUSY,NONSEQ,SEQ} and hburst_e encodings.
//   - function beats(hburst) and function is_wrap(hburst).
//  Sub-module ahb_burst_addr_gen: combinational next-address for the INCR/WRAP rules, inputs cur, hburst.
//  Top holds the FSM, counters and data capture.
// TESTING
//  1. WRAP4, addr=0x1000_0008, hready=1:
//     read_addr 08,0C,00,04 (0x1000_00xx); htrans 10,11,11,11,00.
//  2. INCR8 at 0x2000_0000, hready toggling every 2 cycles:
//     read_addr/htrans hold while hready=0; 8 beats 0x00..0x1C.
//     read_data equals hrdata at each hready=1 data edge.
//  3. SINGLE, addr=0x40: one NONSEQ beat then IDLE; read_data=hrdata at the completion edge.
//  4. hwrite=1 WRAP4 with hrdata=0xDEAD_BEEF: same sequencing; read_data unchanged.
//  5. addr held at 0x100 after its burst completes: no new burst.
//     addr changed to 0x104 mid-burst: a new burst starts only after the return to IDLE.
//  6. rst=1 on the 3rd beat: next cycle htrans=00, read_addr=0, read_data=0.
//     A new burst follows once rst=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and burst helpers for the refill sequencer.
//   htrans_e : AHB transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_e : AHB burst type encoding (SINGLE .. INCR16)
//   state_e  : sequencer FSM states
//   beats()  : number of beats issued for a burst type (INCR is fixed at 4)
//   is_wrap(): 1 for the wrapping burst types
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADDR  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam int BEAT_CNT_W = 5;

  // Undefined-length INCR is treated as a 4-beat burst.
  function automatic logic [BEAT_CNT_W-1:0] beats(input hburst_e hb);
    case (hb)
      HBURST_SINGLE: return 5'd1;
      HBURST_WRAP8,
      HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16,
      HBURST_INCR16: return 5'd16;
      default:       return 5'd4;
    endcase
  endfunction

  function automatic logic is_wrap(input hburst_e hb);
    return (hb == HBURST_WRAP4) || (hb == HBURST_WRAP8) || (hb == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen: combinational next-beat address for AHB bursts.
//   cur    in  ADDR_W  address of the beat currently in its address phase
//   hburst in  3       latched burst type
//   nxt    out ADDR_W  address of the following beat
// INCR types step by the beat stride; WRAP types keep the bits above the
// wrap boundary and let only the in-window bits advance.
module ahb_burst_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] cur,
  input  hburst_e           hburst,
  output logic [ADDR_W-1:0] nxt
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr_addr = cur + STRIDE;
    // Window size in bytes minus one, e.g. 0xF for WRAP4 with 4-byte beats.
    wrap_mask = (ADDR_W'(beats(hburst)) * STRIDE) - ADDR_W'(1);
    if (is_wrap(hburst)) begin
      nxt = (cur & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      nxt = incr_addr;
    end
  end

endmodule

// File: rtl/ahb_transfer_handler.sv
// ahb_transfer_handler: AHB-Lite burst sequencer for I-cache refill.
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous active-high reset
//   addr      in   ADDR_W  requested burst start address (low bits ignored)
//   hwrite    in   1       1 = write burst, read data is not captured
//   hrdata    in   DATA_W  AHB read data
//   hready    in   1       completes data phase / accepts address phase
//   hwdata    in   DATA_W  write data, observed only
//   hburst    in   3       AHB burst type
//   htrans    out  2       AHB transfer type (BUSY never issued)
//   read_addr out  ADDR_W  address of the beat in its address phase
//   read_data out  DATA_W  last captured read beat
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | htrans=IDLE; waiting for a start address different from the last
// ST_ADDR  | address phases of the burst are being issued (NONSEQ then SEQ)
// ST_DRAIN | all addresses accepted; waiting for the final data phase
module ahb_transfer_handler
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [2:0]        hburst,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_W / 8) - ADDR_W'(1));

  state_e                  state_q, state_d;
  htrans_e                 htrans_q, htrans_d;
  logic [ADDR_W-1:0]       read_addr_q, read_addr_d;
  logic [DATA_W-1:0]       read_data_q, read_data_d;
  logic [ADDR_W-1:0]       last_start_q, last_start_d;
  logic                    start_valid_q, start_valid_d;
  hburst_e                 burst_q, burst_d;
  logic                    write_q, write_d;
  logic [BEAT_CNT_W-1:0]   beats_q, beats_d;
  logic [BEAT_CNT_W-1:0]   issued_q, issued_d;
  logic                    pend_q, pend_d;

  logic [ADDR_W-1:0]       start_addr;
  logic [ADDR_W-1:0]       next_addr;
  logic                    start_req;
  logic                    last_accept;
  logic                    unused_hwdata;

  assign unused_hwdata = ^hwdata;

  assign start_addr  = addr & ALIGN_MASK;
  // Re-requesting the address of the previous burst does not refetch it.
  assign start_req   = !start_valid_q || (start_addr != last_start_q);
  assign last_accept = (issued_q + 5'd1) == beats_q;

  ahb_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .cur    (read_addr_q),
    .hburst (burst_q),
    .nxt    (next_addr)
  );

  always_comb begin
    state_d       = state_q;
    htrans_d      = htrans_q;
    read_addr_d   = read_addr_q;
    read_data_d   = read_data_q;
    last_start_d  = last_start_q;
    start_valid_d = start_valid_q;
    burst_d       = burst_q;
    write_d       = write_q;
    beats_d       = beats_q;
    issued_d      = issued_q;
    pend_d        = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          last_start_d  = start_addr;
          start_valid_d = 1'b1;
          burst_d       = hburst_e'(hburst);
          write_d       = hwrite;
          beats_d       = beats(hburst_e'(hburst));
          issued_d      = '0;
          pend_d        = 1'b0;
          read_addr_d   = start_addr;
          htrans_d      = HTRANS_NONSEQ;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          // Same edge accepts this address and completes the previous data phase.
          if (pend_q && !write_q) begin
            read_data_d = hrdata;
          end
          pend_d   = 1'b1;
          issued_d = issued_q + 5'd1;
          if (last_accept) begin
            htrans_d = HTRANS_IDLE;
            state_d  = ST_DRAIN;
          end else begin
            read_addr_d = next_addr;
            htrans_d    = HTRANS_SEQ;
          end
        end
      end
      ST_DRAIN: begin
        if (hready) begin
          if (pend_q && !write_q) begin
            read_data_d = hrdata;
          end
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        pend_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      htrans_q      <= HTRANS_IDLE;
      read_addr_q   <= '0;
      read_data_q   <= '0;
      last_start_q  <= '0;
      start_valid_q <= 1'b0;
      burst_q       <= HBURST_SINGLE;
      write_q       <= 1'b0;
      beats_q       <= '0;
      issued_q      <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      htrans_q      <= htrans_d;
      read_addr_q   <= read_addr_d;
      read_data_q   <= read_data_d;
      last_start_q  <= last_start_d;
      start_valid_q <= start_valid_d;
      burst_q       <= burst_d;
      write_q       <= write_d;
      beats_q       <= beats_d;
      issued_q      <= issued_d;
      pend_q        <= pend_d;
    end
  end

  assign htrans    = htrans_q;
  assign read_addr = read_addr_q;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_ahb_transfer_handler.sv
// tb_ahb_transfer_handler: directed plus randomized bursts against a
// transaction-level reference (beat address list from burst arithmetic,
// read data from the pipelined data-phase rule).
module tb_ahb_transfer_handler;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] read_addr;
  logic [31:0] read_data;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_rd;
  logic [31:0] last_a;

  ahb_transfer_handler #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .hwrite    (hwrite),
    .hrdata    (hrdata),
    .hready    (hready),
    .hwdata    (hwdata),
    .hburst    (hburst),
    .htrans    (htrans),
    .read_addr (read_addr),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int nbeats(input logic [2:0] hb);
    case (hb)
      3'd0:       return 1;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 4;
    endcase
  endfunction

  // Address of beat k: wrap bursts stay inside an aligned window of N*4 bytes.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [2:0] hb, input int k);
    logic [31:0] span;
    logic [31:0] off;
    span = 32'(nbeats(hb) * 4);
    if (hb == 3'd2 || hb == 3'd4 || hb == 3'd6) begin
      off = ((a % span) + 32'(k * 4)) % span;
      return (a - (a % span)) + off;
    end
    return a + 32'(k * 4);
  endfunction

  // mode 0: hready always 1; 1: 0,0,1,1,... ; 2: random
  task automatic run_burst(input logic [31:0] a_in, input logic [2:0] hb, input logic wr,
                           input int mode, input logic fixed_rd,
                           input logic use_mid, input logic [31:0] mid_addr);
    logic [31:0] a;
    int          n;
    int          i;
    int          cyc;
    logic        pend;
    logic        done;
    a      = a_in & ~32'h3;
    n      = nbeats(hb);
    rst    = 1'b0;
    addr   = a_in;
    hburst = hb;
    hwrite = wr;
    @(negedge clk);
    last_a = a;
    i      = 0;
    cyc    = 0;
    pend   = 1'b0;
    done   = 1'b0;
    while (!done && cyc < 400) begin
      if (i < n) begin
        chk("htrans_beat", {30'd0, htrans}, (i == 0) ? 32'd2 : 32'd3);
        chk("read_addr", read_addr, exp_addr(a, hb, i));
      end else begin
        chk("htrans_drain", {30'd0, htrans}, 32'd0);
      end
      chk("read_data", read_data, exp_rd);
      case (mode)
        0:       hready = 1'b1;
        1:       hready = ((cyc / 2) % 2) == 1;
        default: hready = ($urandom_range(0, 2) != 0);
      endcase
      hrdata = fixed_rd ? 32'hDEAD_BEEF : $urandom();
      hwdata = $urandom();
      if (use_mid && i >= 1) addr = mid_addr;
      if (hready) begin
        if (pend && !wr) exp_rd = hrdata;
        if (i < n) begin
          pend = 1'b1;
          i++;
        end else begin
          done = 1'b1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("burst_done", {31'd0, done}, 32'd1);
    chk("htrans_idle", {30'd0, htrans}, 32'd0);
    chk("read_data_idle", read_data, exp_rd);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rhb;
    vectors     = 0;
    miscompares = 0;
    exp_rd      = 32'd0;
    last_a      = 32'hFFFF_FFFF;
    rst         = 1'b1;
    addr        = 32'd0;
    hwrite      = 1'b0;
    hrdata      = 32'd0;
    hready      = 1'b0;
    hwdata      = 32'd0;
    hburst      = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_read_addr", read_addr, 32'd0);
    chk("rst_read_data", read_data, 32'd0);

    // WRAP4 from mid-window, back-to-back ready
    run_burst(32'h1000_0008, 3'd2, 1'b0, 0, 1'b0, 1'b0, 32'd0);
    // INCR8 with hready stalls every other pair of cycles
    run_burst(32'h2000_0000, 3'd5, 1'b0, 1, 1'b0, 1'b0, 32'd0);
    // SINGLE
    run_burst(32'h0000_0040, 3'd0, 1'b0, 0, 1'b0, 1'b0, 32'd0);
    // write WRAP4: read_data must hold
    run_burst(32'h3000_0004, 3'd2, 1'b1, 0, 1'b1, 1'b0, 32'd0);

    // same address held after its burst: no new burst
    run_burst(32'h0000_0100, 3'd3, 1'b0, 0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 6; k++) begin
      hready = 1'b1;
      @(negedge clk);
      chk("hold_no_restart", {30'd0, htrans}, 32'd0);
    end
    // address change mid-burst is deferred until IDLE
    run_burst(32'h0000_0200, 3'd3, 1'b0, 2, 1'b0, 1'b1, 32'h0000_0104);
    run_burst(32'h0000_0104, 3'd4, 1'b0, 2, 1'b0, 1'b0, 32'd0);

    // reset during the third beat's address phase
    addr   = 32'h0000_0300;
    hburst = 3'd3;
    hwrite = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    chk("rstmid_beat0", read_addr, 32'h0000_0300);
    @(negedge clk);
    chk("rstmid_beat1", read_addr, 32'h0000_0304);
    @(negedge clk);
    chk("rstmid_beat2", read_addr, 32'h0000_0308);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_htrans", {30'd0, htrans}, 32'd0);
    chk("rstmid_read_addr", read_addr, 32'd0);
    chk("rstmid_read_data", read_data, 32'd0);
    exp_rd = 32'd0;
    // same address restarts because reset forgot the last start
    run_burst(32'h0000_0300, 3'd6, 1'b0, 0, 1'b0, 1'b0, 32'd0);

    // randomized bursts
    for (int r = 0; r < 24; r++) begin
      ra  = $urandom();
      if ((ra & ~32'h3) == last_a) ra = ra ^ 32'h40;
      rhb = 3'($urandom_range(0, 7));
      run_burst(ra, rhb, 1'($urandom_range(0, 1)), 2, 1'b0, 1'b0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
